// File: rtl/outputs_workload_dispatch.sv
// outputs_workload_dispatch: registered ready/valid fan-out of {id,size} workloads (replicate / split / chunked round-robin)
module outputs_workload_dispatch #(
    parameter int id_width_p       = 8,
    parameter int size_width_p     = 8,
    parameter int num_out_p        = 4,
    parameter int outputs_config_p = 0,
    parameter int chunk_size_p     = 16,
    parameter int width_p          = id_width_p + size_width_p
) (
    input  logic                                clk_i,
    input  logic                                reset_n_i,
    input  logic                                v_i,
    input  logic [width_p-1:0]                  data_i,
    output logic                                ready_and_o,
    output logic [num_out_p-1:0]                v_o,
    output logic [num_out_p-1:0][width_p-1:0]   data_o,
    input  logic [num_out_p-1:0]                ready_and_i
);

    localparam int ptr_w = (num_out_p > 1) ? $clog2(num_out_p) : 1;
    localparam logic [size_width_p-1:0] chunk_c = size_width_p'(chunk_size_p);
    localparam logic [size_width_p-1:0] nout_c  = size_width_p'(num_out_p);
    localparam logic [ptr_w-1:0]        last_c  = ptr_w'(num_out_p - 1);

    if (outputs_config_p < 0 || outputs_config_p > 2) begin : g_bad_cfg
        $error("outputs_workload_dispatch: outputs_config_p must be 0, 1 or 2");
    end

    typedef enum logic [1:0] {IDLE, FANOUT, CHUNK} state_e;

    state_e                                 state;
    logic [ptr_w-1:0]                       rr_ptr;
    logic [size_width_p-1:0]                remaining;
    logic [id_width_p-1:0]                  id_r;

    logic [id_width_p-1:0]                  in_id;
    logic [size_width_p-1:0]                in_size;
    logic [size_width_p-1:0]                q, r;
    logic [num_out_p-1:0][size_width_p-1:0] split_size;
    logic [num_out_p-1:0]                   split_pend;
    logic [size_width_p-1:0]                first_chunk, sent, rem_next, next_chunk;
    logic [ptr_w-1:0]                       rr_next;
    logic [num_out_p-1:0]                   pend_next;

    assign in_id       = data_i[width_p-1 -: id_width_p];
    assign in_size     = data_i[size_width_p-1:0];
    assign ready_and_o = (state == IDLE) & reset_n_i;

    // Even split: quotient everywhere, remainder spread one each over the low channels;
    // a zero-size workload still issues channel 0 so the id reaches the consumer.
    always_comb begin
        q          = in_size / nout_c;
        r          = in_size % nout_c;
        split_size = '0;
        split_pend = '0;
        for (int i = 0; i < num_out_p; i++) begin
            split_size[i] = q + size_width_p'(size_width_p'(i) < r);
            split_pend[i] = split_size[i] != '0;
        end
        split_pend = (in_size == '0) ? num_out_p'(1) : split_pend;
    end

    // Chunk bookkeeping: what goes out first, what is left after a handshake, and where it goes next.
    always_comb begin
        first_chunk = (in_size > chunk_c) ? chunk_c : in_size;
        sent        = data_o[rr_ptr][size_width_p-1:0];
        rem_next    = remaining - sent;
        next_chunk  = (rem_next > chunk_c) ? chunk_c : rem_next;
        rr_next     = (rr_ptr == last_c) ? '0 : rr_ptr + 1'b1;
        pend_next   = v_o & ~ready_and_i;
    end

    // Dispatch FSM; v_o doubles as the pending mask so it only ever comes from registers.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state     <= IDLE;
            v_o       <= '0;
            data_o    <= '0;
            rr_ptr    <= '0;
            remaining <= '0;
            id_r      <= '0;
        end else begin
            case (state)
                IDLE: if (v_i) begin
                    id_r <= in_id;
                    if (outputs_config_p == 2) begin
                        remaining      <= in_size;
                        data_o[rr_ptr] <= {in_id, first_chunk};
                        v_o            <= num_out_p'(1) << rr_ptr;
                        state          <= CHUNK;
                    end else begin
                        for (int i = 0; i < num_out_p; i++)
                            data_o[i] <= (outputs_config_p == 1) ? {in_id, split_size[i]} : data_i;
                        v_o   <= (outputs_config_p == 1) ? split_pend : '1;
                        state <= FANOUT;
                    end
                end
                FANOUT: begin
                    v_o   <= pend_next;
                    state <= (pend_next == '0) ? IDLE : FANOUT;
                end
                CHUNK: if (ready_and_i[rr_ptr]) begin
                    rr_ptr    <= rr_next;
                    remaining <= rem_next;
                    if (rem_next == '0) begin
                        v_o   <= '0;
                        state <= IDLE;
                    end else begin
                        v_o             <= num_out_p'(1) << rr_next;
                        data_o[rr_next] <= {id_r, next_chunk};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_outputs_workload_dispatch.sv
// tb_outputs_workload_dispatch: directed checks of the three dispatch modes on three instances
module tb_outputs_workload_dispatch;

    logic clk = 0;
    logic reset_n = 0;
    int   tests = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    // mode 1, 4 channels
    logic            v1 = 0, rdy1;
    logic [15:0]     d1 = '0;
    logic [3:0]      vo1, ri1 = '1;
    logic [3:0][15:0] do1;
    // mode 0, 3 channels
    logic            v0 = 0, rdy0;
    logic [15:0]     d0 = '0;
    logic [2:0]      vo0, ri0 = '1;
    logic [2:0][15:0] do0;
    // mode 2, 3 channels, chunk 16
    logic            v2 = 0, rdy2;
    logic [15:0]     d2 = '0;
    logic [2:0]      vo2, ri2 = '1;
    logic [2:0][15:0] do2;

    outputs_workload_dispatch #(.id_width_p(8), .size_width_p(8), .num_out_p(4), .outputs_config_p(1)) u1 (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v1), .data_i(d1), .ready_and_o(rdy1),
        .v_o(vo1), .data_o(do1), .ready_and_i(ri1));
    outputs_workload_dispatch #(.id_width_p(8), .size_width_p(8), .num_out_p(3), .outputs_config_p(0)) u0 (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v0), .data_i(d0), .ready_and_o(rdy0),
        .v_o(vo0), .data_o(do0), .ready_and_i(ri0));
    outputs_workload_dispatch #(.id_width_p(8), .size_width_p(8), .num_out_p(3), .outputs_config_p(2), .chunk_size_p(16)) u2 (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v2), .data_i(d2), .ready_and_o(rdy2),
        .v_o(vo2), .data_o(do2), .ready_and_i(ri2));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        // reset held with valid inputs presented
        v0 = 1; d0 = 16'h0101; v1 = 1; d1 = 16'h050a; v2 = 1; d2 = 16'h0101;
        repeat (3) step();
        chk("rst_vo1", vo1, 0); chk("rst_rdy1", rdy1, 0);
        chk("rst_vo0", vo0, 0); chk("rst_rdy0", rdy0, 0);
        chk("rst_vo2", vo2, 0); chk("rst_rdy2", rdy2, 0);
        chk("rst_do1", do1, 0);
        v0 = 0; v1 = 0; v2 = 0; reset_n = 1;
        step();
        chk("post_rst_rdy1", rdy1, 1); chk("post_rst_vo1", vo1, 0);

        // mode 1 split 10 over 4 with ch2 stalled
        ri1 = 4'b1011; v1 = 1; d1 = 16'h050a;
        step(); v1 = 0;
        chk("split_vo", vo1, 4'b1111);
        chk("split_ch0", do1[0], 16'h0503); chk("split_ch1", do1[1], 16'h0503);
        chk("split_ch2", do1[2], 16'h0502); chk("split_ch3", do1[3], 16'h0502);
        chk("split_busy", rdy1, 0);
        repeat (4) begin
            step();
            chk("stall_vo", vo1, 4'b0100); chk("stall_ch2", do1[2], 16'h0502); chk("stall_rdy", rdy1, 0);
        end
        ri1 = 4'b1111;
        step();
        chk("stall_done_vo", vo1, 0); chk("stall_done_rdy", rdy1, 1);

        // mode 1 small sizes
        v1 = 1; d1 = 16'h0902;
        step(); v1 = 0;
        chk("sz2_vo", vo1, 4'b0011); chk("sz2_ch0", do1[0], 16'h0901); chk("sz2_ch1", do1[1], 16'h0901);
        step();
        chk("sz2_end", vo1, 0);
        v1 = 1; d1 = 16'h0900;
        step(); v1 = 0;
        chk("sz0_vo", vo1, 4'b0001); chk("sz0_ch0", do1[0], 16'h0900);
        step();
        chk("sz0_end", vo1, 0);

        // mode 0 replicate
        v0 = 1; d0 = 16'h0764;
        step(); v0 = 0;
        chk("rep_vo", vo0, 3'b111);
        chk("rep_ch0", do0[0], 16'h0764); chk("rep_ch1", do0[1], 16'h0764); chk("rep_ch2", do0[2], 16'h0764);
        chk("rep_busy", rdy0, 0);
        step();
        chk("rep_end_vo", vo0, 0); chk("rep_end_rdy", rdy0, 1);

        // mode 2 chunks: 40 then 20, pointer carried over
        v2 = 1; d2 = 16'h0328;
        step(); v2 = 0;
        chk("c40_1_vo", vo2, 3'b001); chk("c40_1_d", do2[0], 16'h0310);
        step();
        chk("c40_2_vo", vo2, 3'b010); chk("c40_2_d", do2[1], 16'h0310);
        step();
        chk("c40_3_vo", vo2, 3'b100); chk("c40_3_d", do2[2], 16'h0308);
        step();
        chk("c40_end_vo", vo2, 0); chk("c40_end_rdy", rdy2, 1);
        v2 = 1; d2 = 16'h0314;
        step(); v2 = 0;
        chk("c20_1_vo", vo2, 3'b001); chk("c20_1_d", do2[0], 16'h0310);
        step();
        chk("c20_2_vo", vo2, 3'b010); chk("c20_2_d", do2[1], 16'h0304);
        step();
        chk("c20_end_vo", vo2, 0);

        // mode 2 reset mid-transfer; pointer sits at ch2 beforehand
        v2 = 1; d2 = 16'h0428;
        step(); v2 = 0;
        chk("mid_1_vo", vo2, 3'b100); chk("mid_1_d", do2[2], 16'h0410);
        step();
        chk("mid_2_vo", vo2, 3'b001); chk("mid_2_d", do2[0], 16'h0410);
        reset_n = 0; ri2 = 3'b000;
        step();
        chk("mid_rst_vo", vo2, 0); chk("mid_rst_rdy", rdy2, 0);
        reset_n = 1; ri2 = 3'b111; v2 = 1; d2 = 16'h0405;
        step(); v2 = 0;
        chk("after_rst_vo", vo2, 3'b001); chk("after_rst_d", do2[0], 16'h0405);
        step();
        chk("after_rst_end", vo2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
